// File: rtl/seg_readback_if.sv
// Readback bus between the 7-segment display lines and the decoder:
// the segment source drives master, the decoder is the slave.
interface seg_readback_if #(
  parameter int CNT_W = 8
);
  logic [6:0]       seg_in;
  logic             common_cathode;
  logic             clr_counts;
  logic [3:0]       digit;
  logic [1:0]       kind;
  logic             have_value;
  logic             new_valid;
  logic [CNT_W-1:0] change_count;
  logic [CNT_W-1:0] invalid_count;

  modport master (
    output seg_in, common_cathode, clr_counts,
    input  digit, kind, have_value, new_valid, change_count, invalid_count
  );
  modport slave (
    input  seg_in, common_cathode, clr_counts,
    output digit, kind, have_value, new_valid, change_count, invalid_count
  );
endinterface

// File: rtl/seg_readback_decoder.sv
// Samples display segment lines, waits for a stable pattern, decodes it back
// to a digit/symbol and keeps saturating change / invalid counters.
module seg_readback_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic           clk,
  input  logic           rst,
  seg_readback_if.slave  bus
);
  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  logic [6:0]       seg_s1, seg_s2, norm, cand, accepted;
  logic             cc_s1, cc_s2;
  logic [3:0]       cnt;
  logic             accept;
  logic [3:0]       dec_digit, digit_q;
  logic [1:0]       dec_kind, kind_q;
  logic             have_q, nv_q;
  logic [CNT_W-1:0] chg_q, inv_q;

  always_comb norm = cc_s2 ? seg_s2 : ~seg_s2;

  // Fires once per stable run; a run back onto the accepted pattern is ignored.
  always_comb accept = (norm == cand) && (cnt == STABLE - 4'd1) &&
                       (!have_q || (cand != accepted));

  always_comb begin
    dec_digit = 4'd0;
    dec_kind  = 2'd0;
    case (cand)
      7'h3F: dec_digit = 4'd0;
      7'h06: dec_digit = 4'd1;
      7'h5B: dec_digit = 4'd2;
      7'h4F: dec_digit = 4'd3;
      7'h66: dec_digit = 4'd4;
      7'h6D: dec_digit = 4'd5;
      7'h7D: dec_digit = 4'd6;
      7'h07: dec_digit = 4'd7;
      7'h7F: dec_digit = 4'd8;
      7'h6F: dec_digit = 4'd9;
      7'h00: dec_kind  = 2'd1;
      7'h40: dec_kind  = 2'd2;
      default: dec_kind = 2'd3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s1 <= '0; seg_s2 <= '0; cc_s1 <= 1'b0; cc_s2 <= 1'b0;
      cand   <= '0; cnt    <= '0;
    end else begin
      seg_s1 <= bus.seg_in;         seg_s2 <= seg_s1;
      cc_s1  <= bus.common_cathode; cc_s2  <= cc_s1;
      if (norm != cand) begin
        cand <= norm;
        cnt  <= 4'd1;
      end else if (cnt < STABLE) begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      accepted <= '0; digit_q <= '0; kind_q <= 2'd1;
      have_q   <= 1'b0; nv_q  <= 1'b0;
      chg_q    <= '0; inv_q   <= '0;
    end else begin
      nv_q <= accept;
      if (accept) begin
        accepted <= cand;
        digit_q  <= dec_digit;
        kind_q   <= dec_kind;
        have_q   <= 1'b1;
      end
      // Clear wins over a same-cycle increment.
      if (bus.clr_counts) begin
        chg_q <= '0;
        inv_q <= '0;
      end else if (accept) begin
        if (!(&chg_q)) chg_q <= chg_q + 1'b1;
        if ((dec_kind == 2'd3) && !(&inv_q)) inv_q <= inv_q + 1'b1;
      end
    end
  end

  assign bus.digit         = digit_q;
  assign bus.kind          = kind_q;
  assign bus.have_value    = have_q;
  assign bus.new_valid     = nv_q;
  assign bus.change_count  = chg_q;
  assign bus.invalid_count = inv_q;
endmodule

// File: doc/seg_readback_decoder.md
Name: seg_readback_decoder

Overview:
- Receiving end of the dice unit's 7-segment output interface.
- Samples the seven segment lines as driven to the display, normalises them for display polarity and waits until they are stable.
- Decodes the stable pattern back to a digit/symbol, pulses a strobe on every newly accepted value and keeps change and error counters.
- Used as an on-chip self-test/readback monitor and as a bench-side checker of the display path.

Parameters:
- STABLE_CYCLES, 4, consecutive identical synchronised samples required before a pattern is accepted (legal range 2..15).
- CNT_W, 8, width of the change and invalid counters.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- seg_in  input  7  segment lines, bit0=a … bit6=g; may be asynchronous to clk
- common_cathode  input  1  1 = segments active-high; 0 = active-low (inverted)
- clr_counts  input  1  synchronous clear of both counters
- digit  output  4  decoded value 0..9 of the last accepted pattern
- kind  output  2  class of last accepted pattern: 0 = digit, 1 = blank, 2 = dash (g only), 3 = invalid
- have_value  output  1  a pattern has been accepted since reset
- new_valid  output  1  one-cycle strobe when a new value is accepted
- change_count  output  CNT_W  number of accepted changes, saturating
- invalid_count  output  CNT_W  number of accepted patterns with kind=3, saturating

Behaviour:
- Synchroniser:
  - seg_in and common_cathode each pass through a 2-flop synchroniser; s2 denotes the second stage.
  - norm = common_cathode_s2 ? seg_s2 : ~seg_s2.
  - A polarity flip therefore appears as a pattern change.
- Stability filter: registers cand[6:0] and run counter cnt.
  - Each cycle, if norm != cand: cand <= norm, cnt <= 1.
  - Otherwise, if cnt < STABLE_CYCLES: cnt <= cnt + 1.
  - Accept event: norm == cand AND cnt == STABLE_CYCLES-1 AND (have_value==0 OR cand != accepted).
  - The event fires once per stable run. Re-stabilising on the already accepted pattern (glitch and return) does not fire.
- On an accept event, registered and visible in the next cycle:
  - accepted <= cand; digit and kind updated from the decode of cand.
  - have_value <= 1; new_valid <= 1 for exactly one cycle.
  - change_count increments, saturating at all-ones.
  - invalid_count increments (saturating) if kind becomes 3.
- Latency: a clean pattern held on seg_in produces new_valid exactly 2+STABLE_CYCLES clock edges after the first edge that samples it (6 for the default).
- Decode (active-high, gfedcba) → kind/digit:
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9; kind=0 for all of these.
  - 0x00 → kind=1, digit=0.
  - 0x40 → kind=2, digit=0.
  - Anything else → kind=3, digit=0.
- Reset (rst=1 on a clock edge):
  - Synchronisers, cand and cnt are cleared.
  - accepted=0x00, digit=0, kind=1, have_value=0, new_valid=0, both counters=0.
  - Reset mid-run aborts any pending acceptance; the filter restarts from scratch afterwards.
- clr_counts:
  - Zeroes both counters on the next edge and takes priority over a same-cycle increment.
  - Does not affect digit, kind, have_value or the filter.
- Patterns toggling faster than STABLE_CYCLES never produce an accept event.
- A blank pattern after reset is accepted (have_value was 0) and counted.

Test Plan:
- Reset, then common_cathode=1, seg_in=0x5B held → new_valid single pulse at edge 6; digit=2, kind=0, change_count=1, have_value=1.
- common_cathode=0, seg_in=~0x6D=0x12 → digit=5, kind=0. Then flip common_cathode to 1 with seg_in unchanged → accepts 0x6D inverted = 0x12, kind=3, invalid_count=1.
- Accept 0x06, glitch seg_in to 0x7F for 2 cycles, return to 0x06 → no new_valid; digit stays 1; change_count unchanged.
- Toggle seg_in between 0x3F and 0x06 every 3 cycles for 50 cycles → no accept events. Then hold 0x3F → one accept with digit=0.
- Drive 255+ distinct alternating accepts (0x3F/0x06) → change_count saturates at 0xFF. Assert clr_counts in the same cycle as an accept → counters read 0, digit updated.
- Assert rst at cnt=3 of a pending 0x40 run → no new_valid. Outputs return to digit=0, kind=1, have_value=0. After release, 0x40 held → accept with kind=2 at edge 6.
